// File: rtl/uart_msg_sched_if.sv
// uart_msg_sched_if
//   Groups the request/acknowledge bus of the four telemetry sources, the
//   channel enable mask, the byte stream towards the UART transmitter and the
//   scheduler status into one bundle.
//
//   master : the environment side (message sources, register bank, UART TX)
//   slave  : the scheduler (uart_msg_sched)
//
//   Signals
//     u_req[3:0]   request per channel, held until the matching u_ack bit
//     u_ack[3:0]   one-cycle acknowledge when a channel's message is latched
//     u0..u3_msg   64-bit message per channel (xp, yp, xi, yi)
//     ch_en[3:0]   channel enable mask; a disabled channel is never granted
//     tx_data      byte presented to the UART transmitter
//     tx_valid     tx_data is valid
//     tx_ready     transmitter takes the byte when tx_valid && tx_ready
//     busy         scheduler is inside a frame or its trailing gap
//     cur_ch       channel of the frame in progress / last granted channel
interface uart_msg_sched_if;
  logic [3:0]  u_req;
  logic [3:0]  u_ack;
  logic [63:0] u0_msg;
  logic [63:0] u1_msg;
  logic [63:0] u2_msg;
  logic [63:0] u3_msg;
  logic [3:0]  ch_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [1:0]  cur_ch;

  modport master (
    output u_req, u0_msg, u1_msg, u2_msg, u3_msg, ch_en, tx_ready,
    input  u_ack, tx_data, tx_valid, busy, cur_ch
  );

  modport slave (
    input  u_req, u0_msg, u1_msg, u2_msg, u3_msg, ch_en, tx_ready,
    output u_ack, tx_data, tx_valid, busy, cur_ch
  );
endinterface

// File: rtl/uart_msg_sched.sv
// uart_msg_sched
//   Round-robin scheduler sharing one UART byte transmitter between four
//   64-bit telemetry sources (ch0 xp, ch1 yp, ch2 xi, ch3 yi). A granted
//   message is framed as
//     header (HDR_BASE | ch), MSG_BYTES payload bytes MSB first, XOR checksum
//   and streamed over a valid/ready byte interface, followed by GAP_CYCLES
//   idle cycles before the next grant.
//
//   Ports
//     clk_50m  50 MHz UART clock
//     reset    synchronous, active-high reset
//     bus      uart_msg_sched_if.slave (requests, messages, enable mask,
//              TX byte stream, busy, cur_ch)
//
//   Parameters
//     MSG_BYTES   payload bytes per message (1..8), taken from the top of uN_msg
//     HDR_BASE    header base; the channel number is OR-ed into bits [1:0]
//     GAP_CYCLES  idle cycles after each checksum byte (0 allowed)
module uart_msg_sched #(
  parameter int          MSG_BYTES  = 8,
  parameter logic [7:0]  HDR_BASE   = 8'hA0,
  parameter int          GAP_CYCLES = 16
) (
  input  logic             clk_50m,
  input  logic             reset,
  uart_msg_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam int         GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [3:0] LAST_IDX = 4'(MSG_BYTES);
  // Unused when GAP_CYCLES is 0; the truncating cast keeps it legal then.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  // Payload byte idx counted from the MSB end of the message.
  function automatic logic [7:0] msg_byte(input logic [63:0] msg,
                                          input logic [2:0]  idx);
    logic [63:0] shifted;
    shifted = msg << {idx, 3'b000};
    return shifted[63:56];
  endfunction

  // Running XOR checksum over the frame bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] csum,
                                          input logic [7:0] data);
    return csum ^ data;
  endfunction

  state_t           state_r;
  logic [1:0]       last_r;
  logic [1:0]       cur_ch_r;
  logic [63:0]      msg_r;
  logic [7:0]       csum_r;
  logic [3:0]       idx_r;
  logic [GAP_W-1:0] gap_r;
  logic [3:0]       u_ack_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;
  logic             busy_r;

  logic [3:0]       elig_s;
  logic [7:0]       elig_dbl_s;
  logic [2:0]       rot_base_s;
  logic [3:0]       elig_rot_s;
  logic [1:0]       grant_off_s;
  logic             grant_vld_s;
  logic [1:0]       grant_ch_s;
  logic [63:0]      grant_msg_s;
  logic [7:0]       grant_hdr_s;

  // Round-robin pick: rotate the eligible set so bit 0 is the channel right
  // after the last grant, then take the lowest set bit of the rotated vector.
  always_comb begin
    elig_s      = bus.u_req & bus.ch_en;
    elig_dbl_s  = {elig_s, elig_s};
    rot_base_s  = {1'b0, last_r} + 3'd1;
    elig_rot_s  = elig_dbl_s[rot_base_s +: 4];
    grant_vld_s = (elig_s != 4'b0000);
    if (elig_rot_s[0]) begin
      grant_off_s = 2'd0;
    end else if (elig_rot_s[1]) begin
      grant_off_s = 2'd1;
    end else if (elig_rot_s[2]) begin
      grant_off_s = 2'd2;
    end else begin
      grant_off_s = 2'd3;
    end
    grant_ch_s  = last_r + 2'd1 + grant_off_s;
    grant_hdr_s = HDR_BASE | {6'b000000, grant_ch_s};
  end

  // Message of the channel being granted.
  always_comb begin
    case (grant_ch_s)
      2'd0:    grant_msg_s = bus.u0_msg;
      2'd1:    grant_msg_s = bus.u1_msg;
      2'd2:    grant_msg_s = bus.u2_msg;
      2'd3:    grant_msg_s = bus.u3_msg;
      default: grant_msg_s = bus.u0_msg;
    endcase
  end

  // Frame sequencer: grant, header, payload, checksum, trailing gap.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_r     <= 2'd3;
      cur_ch_r   <= 2'd0;
      msg_r      <= 64'h0;
      csum_r     <= 8'h00;
      idx_r      <= 4'd0;
      gap_r      <= {GAP_W{1'b0}};
      u_ack_r    <= 4'b0000;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // u_ack is a single-cycle pulse; only the grant branch raises it.
      u_ack_r <= 4'b0000;
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            msg_r      <= grant_msg_s;
            last_r     <= grant_ch_s;
            cur_ch_r   <= grant_ch_s;
            u_ack_r    <= 4'b0001 << grant_ch_s;
            tx_data_r  <= grant_hdr_s;
            tx_valid_r <= 1'b1;
            csum_r     <= grant_hdr_s;
            idx_r      <= 4'd0;
            busy_r     <= 1'b1;
            state_r    <= ST_HDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (bus.tx_ready) begin
            tx_data_r <= msg_byte(msg_r, 3'd0);
            csum_r    <= csum_add(csum_r, msg_byte(msg_r, 3'd0));
            idx_r     <= 4'd1;
            state_r   <= ST_DATA;
          end else begin
            state_r <= ST_HDR;
          end
        end
        ST_DATA: begin
          // idx_r counts payload bytes already loaded; once all are loaded the
          // running checksum already covers the last one.
          if (bus.tx_ready) begin
            if (idx_r == LAST_IDX) begin
              tx_data_r <= csum_r;
              state_r   <= ST_CSUM;
            end else begin
              tx_data_r <= msg_byte(msg_r, idx_r[2:0]);
              csum_r    <= csum_add(csum_r, msg_byte(msg_r, idx_r[2:0]));
              idx_r     <= idx_r + 4'd1;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_CSUM: begin
          if (bus.tx_ready) begin
            tx_valid_r <= 1'b0;
            if (GAP_CYCLES == 0) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              gap_r   <= GAP_LOAD;
              state_r <= ST_GAP;
            end
          end else begin
            state_r <= ST_CSUM;
          end
        end
        ST_GAP: begin
          // Counter runs GAP_CYCLES-1 .. 0, giving exactly GAP_CYCLES cycles.
          if (gap_r == {GAP_W{1'b0}}) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.u_ack    = u_ack_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.busy     = busy_r;
  assign bus.cur_ch   = cur_ch_r;

endmodule
